div_share_sched: RTL and testbench
==================================

// Module: div_share_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined signed divider (divider_top) among NREQ requesters
//  in cal_position. Issues at most one divide per cycle; tracks each op's requester id in order.
//  Returns {id, quotient, remainder} through a credit-bounded result FIFO with valid/ready.
//  Credits guarantee the non-stallable divider never overflows the result FIFO.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  N      32  dividend / quotient width (matches divider_top N)
//  M      32  divisor / remainder width (matches divider_top M)
//  CRED   64  max ops in flight + buffered; result FIFO and tag FIFO depth; power of 2, >= N+2
//  IDW    $clog2(NREQ) (localparam) requester id width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  req_valid      in   NREQ    per-requester request valid
//  req_ready      out  NREQ    per-requester accept; one-hot or zero
//  req_dividend   in   NREQ*N  packed dividends, requester i at [i*N +: N]
//  req_divisor    in   NREQ*M  packed divisors, requester i at [i*M +: M]
//  div_data_rdy   out  1       issue strobe to divider data_rdy
//  div_dividend   out  N       to divider dividend
//  div_divisor    out  M       to divider divisor
//  div_res_rdy    in   1       divider res_rdy
//  div_merchant   in   N       divider quotient
//  div_remainder  in   M       divider remainder
//  res_valid      out  1       result available
//  res_ready      in   1       consumer accepts result
//  res_id         out  IDW     requester id of result
//  res_quot       out  N       quotient
//  res_rem        out  M       remainder
//  busy           out  1       credits_used != 0
//  err_orphan     out  1       sticky: div_res_rdy seen with tag FIFO empty
// BEHAVIOUR
//  - Reset: req_ready=0, div_data_rdy=0, div_dividend/div_divisor=0, res_valid=0, res_id/quot/rem=0,
//    busy=0, err_orphan=0, RR pointer=0, tag/result FIFOs empty, credits_used=0.
//  - Reset mid-operation discards all in-flight tags and buffered results. The parent resets the
//    divider in the same cycle. Late divider outputs hit an empty tag FIFO: dropped, err_orphan set.
//  - credits_used = tag FIFO count + result FIFO count. can_issue = credits_used < CRED.
//  - Arbitration (combinational): grant = first i with req_valid[i], searching from ptr upward,
//    modulo NREQ. req_ready = grant & {NREQ{can_issue}}. Issue fires when any bit of req_ready is 1.
//  - Issue is registered, 1 cycle. Next cycle div_data_rdy=1 with the granted operands; otherwise
//    div_data_rdy=0 and operands hold. Grant id pushes to the tag FIFO at the issue edge.
//    ptr <= (grant_id+1) mod NREQ.
//  - No issue when can_issue=0 or no req_valid. ptr unchanged; back-to-back issue every cycle allowed.
//  - On div_res_rdy: pop tag, push {tag, div_merchant, div_remainder} to the result FIFO in the same edge.
//    Divider is in-order, so tags match. Push never meets a full FIFO; an assertion guards this.
//  - Result FIFO is first-word-fall-through. res_* valid when not empty; pop on res_valid&res_ready.
//  - Simultaneous issue + result + pop: all occur; credits_used += issue - pop (result move is net 0).
//  - Latency: req handshake -> res_valid = 1 (issue reg) + divider latency (N) + 1 (FIFO write) cycles.
//  - Request-side outputs (req_ready) may depend combinationally on req_valid; no other comb paths.
// CONFIGURATION
//  DIV_ZERO_CHK_EN defined: adds port res_dz (out, 1, reset 0) and a dz bit per tag entry, set when
//    the issued divisor==0. On a dz result: res_quot forced to {1'b0,{N-1{1'b1}}}, res_rem = dividend
//    low M bits (dividend kept in the tag entry), res_dz=1. The divider is still issued so ordering holds.
//  Undefined: no res_dz port; divider outputs are passed through unmodified for any divisor.
// TESTING
//  1) Single: req0 dividend=29 divisor=5 -> div_data_rdy 1 cycle later; res id=0 quot=5 rem=4, N+2 cycles after handshake.
//  2) All 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; results in same id order.
//  3) res_ready=0, req0 always valid -> exactly CRED accepts then req_ready=0; one pop -> one more accept next cycle.
//  4) Signed: -29/5 from req2 -> id=2 quot=-5; 29/-5 -> quot=-5.
//  5) rst asserted with 10 ops in flight -> next cycle all outputs at reset values. Divider output pulse
//     with empty tag FIFO -> err_orphan=1 until rst.
//  6) DIV_ZERO_CHK_EN: 100/0 -> res_dz=1, res_quot=32'h7FFFFFFF, res_rem=100; following 7/2 -> res_dz=0 quot=3 rem=1.

Source files
------------

// File: rtl/div_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_sched
//  Purpose  : Round-robin scheduler sharing one pipelined signed divider among
//             NREQ requesters. Issues at most one divide per cycle, tracks the
//             requester id of each in-flight op in order and returns
//             {id, quotient, remainder} through a credit-bounded FWFT FIFO.
//  Options  : DIV_ZERO_CHK_EN - adds res_dz and saturates divide-by-zero
//             results (quotient = max positive, remainder = dividend).
//  Revision : 1.0 - initial release
// ============================================================================
module div_share_sched #(
  parameter  int NREQ = 4,
  parameter  int N    = 32,
  parameter  int M    = 32,
  parameter  int CRED = 64,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*M-1:0] req_divisor,
  output logic              div_data_rdy,
  output logic [N-1:0]      div_dividend,
  output logic [M-1:0]      div_divisor,
  input  logic              div_res_rdy,
  input  logic [N-1:0]      div_merchant,
  input  logic [M-1:0]      div_remainder,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [N-1:0]      res_quot,
  output logic [M-1:0]      res_rem,
  output logic              busy,
  output logic              err_orphan
`ifdef DIV_ZERO_CHK_EN
  ,
  output logic              res_dz
`endif
);

  localparam int PW = $clog2(CRED);
  localparam int CW = PW + 1;
`ifdef DIV_ZERO_CHK_EN
  // Tag carries the dz flag and the dividend so a zero-divisor result can be rebuilt
  localparam int TW = IDW + 1 + N;
  localparam int RW = IDW + N + M + 1;
`else
  localparam int TW = IDW;
  localparam int RW = IDW + N + M;
`endif

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           div_data_rdy_q, div_data_rdy_d;
  logic [N-1:0]   div_dividend_q, div_dividend_d;
  logic [M-1:0]   div_divisor_q, div_divisor_d;
  logic [PW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]  tag_cnt_q, tag_cnt_d;
  logic [PW-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CW-1:0]  res_cnt_q, res_cnt_d;
  logic           err_orphan_q, err_orphan_d;
  logic [TW-1:0]  tag_mem_q [CRED];
  logic [RW-1:0]  res_mem_q [CRED];

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [N-1:0]    sel_dividend;
  logic [M-1:0]    sel_divisor;
  logic [CW:0]     credits;
  logic            can_issue, issue, tag_pop, res_push, res_pop;
  logic [TW-1:0]   tag_wdata, tag_rdata;
  logic [RW-1:0]   res_wdata, res_rdata;

  // Credits cover both divider occupancy and buffered results, so the
  // non-stallable divider can never land a result in a full FIFO
  assign credits   = {1'b0, tag_cnt_q} + {1'b0, res_cnt_q};
  assign can_issue = credits < (CW+1)'(CRED);
  assign busy      = credits != '0;
  assign tag_rdata = tag_mem_q[tag_rd_q];
  assign res_rdata = res_mem_q[res_rd_q];
  assign tag_pop   = div_res_rdy && (tag_cnt_q != '0);
  assign res_push  = tag_pop;
  assign res_valid = res_cnt_q != '0;
  assign res_pop   = res_valid && res_ready;
  assign req_ready = (rst || !can_issue) ? '0 : grant;
  assign issue     = |req_ready;

  assign div_data_rdy = div_data_rdy_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign err_orphan   = err_orphan_q;

  // Round-robin search: first valid requester at or above ptr, wrapping
  always_comb begin
    logic found;
    found        = 1'b0;
    grant        = '0;
    grant_id     = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
          found        = 1'b1;
          grant[i]     = 1'b1;
          grant_id     = IDW'(i);
          sel_dividend = req_dividend[i*N +: N];
          sel_divisor  = req_divisor[i*M +: M];
        end
      end
    end
  end

  // Tag entry written at issue and result entry built from the oldest tag
  always_comb begin
`ifdef DIV_ZERO_CHK_EN
    logic [IDW-1:0] t_id;
    logic           t_dz;
    logic [N-1:0]   t_dd;
    tag_wdata = {grant_id, (sel_divisor == '0), sel_dividend};
    t_id      = tag_rdata[TW-1 -: IDW];
    t_dz      = tag_rdata[N];
    t_dd      = tag_rdata[N-1:0];
    res_wdata = {t_id,
                 t_dz ? {1'b0, {(N-1){1'b1}}} : div_merchant,
                 t_dz ? M'(t_dd) : div_remainder,
                 t_dz};
`else
    tag_wdata = grant_id;
    res_wdata = {tag_rdata, div_merchant, div_remainder};
`endif
  end

  // Next-state: issue register, pointer, FIFO pointers/counts, orphan flag
  always_comb begin
    ptr_d          = ptr_q;
    div_data_rdy_d = issue;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    tag_wr_d       = tag_wr_q;
    tag_rd_d       = tag_rd_q;
    tag_cnt_d      = tag_cnt_q;
    res_wr_d       = res_wr_q;
    res_rd_d       = res_rd_q;
    res_cnt_d      = res_cnt_q;
    err_orphan_d   = err_orphan_q | (div_res_rdy && (tag_cnt_q == '0));
    if (issue) begin
      ptr_d          = IDW'((int'(grant_id) + 1) % NREQ);
      div_dividend_d = sel_dividend;
      div_divisor_d  = sel_divisor;
      tag_wr_d       = tag_wr_q + 1'b1;
    end
    if (tag_pop) tag_rd_d = tag_rd_q + 1'b1;
    if (issue && !tag_pop)      tag_cnt_d = tag_cnt_q + 1'b1;
    else if (!issue && tag_pop) tag_cnt_d = tag_cnt_q - 1'b1;
    if (res_push) res_wr_d = res_wr_q + 1'b1;
    if (res_pop)  res_rd_d = res_rd_q + 1'b1;
    if (res_push && !res_pop)      res_cnt_d = res_cnt_q + 1'b1;
    else if (!res_push && res_pop) res_cnt_d = res_cnt_q - 1'b1;
  end

  // State registers; reset discards every in-flight tag and buffered result
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      div_data_rdy_q <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      tag_wr_q       <= '0;
      tag_rd_q       <= '0;
      tag_cnt_q      <= '0;
      res_wr_q       <= '0;
      res_rd_q       <= '0;
      res_cnt_q      <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      div_data_rdy_q <= div_data_rdy_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      tag_wr_q       <= tag_wr_d;
      tag_rd_q       <= tag_rd_d;
      tag_cnt_q      <= tag_cnt_d;
      res_wr_q       <= res_wr_d;
      res_rd_q       <= res_rd_d;
      res_cnt_q      <= res_cnt_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  // FIFO storage; contents need no reset since counts gate visibility
  always_ff @(posedge clk) begin
    if (issue)    tag_mem_q[tag_wr_q] <= tag_wdata;
    if (res_push) res_mem_q[res_wr_q] <= res_wdata;
  end

  // Result outputs read as zero whenever the FIFO is empty
  always_comb begin
    res_id   = '0;
    res_quot = '0;
    res_rem  = '0;
`ifdef DIV_ZERO_CHK_EN
    res_dz   = 1'b0;
    if (res_valid) {res_id, res_quot, res_rem, res_dz} = res_rdata;
`else
    if (res_valid) {res_id, res_quot, res_rem} = res_rdata;
`endif
  end

  a_res_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(res_push && (res_cnt_q == CW'(CRED))));

endmodule
`default_nettype wire

// File: tb/tb_div_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_share_sched
//  Purpose  : Scoreboard bench for div_share_sched with a behavioural
//             N-stage pipelined signed divider. Honours DIV_ZERO_CHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_sched;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int M    = 32;
  localparam int CRED = 64;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   q;
    logic [M-1:0]   r;
    logic           dz;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*M-1:0] req_divisor;
  logic              div_data_rdy;
  logic [N-1:0]      div_dividend;
  logic [M-1:0]      div_divisor;
  logic              div_res_rdy;
  logic [N-1:0]      div_merchant;
  logic [M-1:0]      div_remainder;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [N-1:0]      res_quot;
  logic [M-1:0]      res_rem;
  logic              busy;
  logic              err_orphan;
`ifdef DIV_ZERO_CHK_EN
  logic              res_dz;
`endif

  logic [N-1:0] op_dd [NREQ];
  logic [M-1:0] op_dv [NREQ];
  logic [N-1:0] exp_q [NREQ];
  logic [M-1:0] exp_r [NREQ];
  logic         exp_dz [NREQ];

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  int   m_ptr = 0;
  logic inj;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign req_dividend[g*N +: N] = op_dd[g];
    assign req_divisor[g*M +: M]  = op_dv[g];
  end

  div_share_sched #(.NREQ(NREQ), .N(N), .M(M), .CRED(CRED)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_data_rdy(div_data_rdy), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_res_rdy(div_res_rdy), .div_merchant(div_merchant), .div_remainder(div_remainder),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_quot(res_quot), .res_rem(res_rem),
    .busy(busy), .err_orphan(err_orphan)
`ifdef DIV_ZERO_CHK_EN
    , .res_dz(res_dz)
`endif
  );

  // Behavioural divider: in-order, N-cycle latency, reset along with the DUT
  logic [M-1:0]        dv_safe;
  logic signed [N-1:0] dq;
  logic signed [M-1:0] dr;
  logic [N-1:0]        pv;
  logic [N-1:0][N-1:0] pq;
  logic [N-1:0][M-1:0] pr;
  assign dv_safe = (div_divisor == '0) ? M'(1) : div_divisor;
  assign dq      = $signed(div_dividend) / $signed(dv_safe);
  assign dr      = $signed(div_dividend) % $signed(dv_safe);
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pq <= '0;
      pr <= '0;
    end else begin
      pv <= {pv[N-2:0], div_data_rdy};
      pq <= {pq[N-2:0], dq};
      pr <= {pr[N-2:0], dr};
    end
  end
  assign div_res_rdy   = pv[N-1] | inj;
  assign div_merchant  = pq[N-1];
  assign div_remainder = pr[N-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-side model: predicts grants and credits, pushes expected results
  always @(negedge clk) begin
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  gidx;
    logic            hit;
    logic [NREQ-1:0] eg;
    if (rst) begin
      sb.delete();
      m_cnt = 0;
      m_ptr = 0;
    end else begin
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      hit  = 1'b0;
      gidx = '0;
      for (int k = 0; k < NREQ; k++) begin
        idx = IDW'((m_ptr + k) % NREQ);
        if (!hit && req_valid[idx]) begin
          hit  = 1'b1;
          gidx = idx;
        end
      end
      if (m_cnt >= CRED) hit = 1'b0;
      eg = hit ? NREQ'(1) << gidx : '0;
      chk("req_ready", 64'(req_ready), 64'(eg));
      if (hit) begin
        sb.push_back('{id: gidx, q: exp_q[gidx], r: exp_r[gidx], dz: exp_dz[gidx]});
        m_ptr = (int'(gidx) + 1) % NREQ;
        m_cnt++;
      end
      if (res_valid && res_ready) m_cnt--;
    end
  end

  // Result monitor: compares every consumed result against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL res_unexpected: got id=%0d quot=%0h with nothing expected", res_id, res_quot);
      end else begin
        e = sb.pop_front();
        chk("res_id", 64'(res_id), 64'(e.id));
        chk("res_quot", 64'(res_quot), 64'(e.q));
        chk("res_rem", 64'(res_rem), 64'(e.r));
`ifdef DIV_ZERO_CHK_EN
        chk("res_dz", 64'(res_dz), 64'(e.dz));
`endif
      end
    end
  end

  task automatic set_op(input logic [IDW-1:0] id, input logic [N-1:0] dd, input logic [M-1:0] dv,
                        input logic [N-1:0] q, input logic [M-1:0] r, input logic dz);
    op_dd[id]  = dd;
    op_dv[id]  = dv;
    exp_q[id]  = q;
    exp_r[id]  = r;
    exp_dz[id] = dz;
  endtask

  // Returns just after the handshake edge with req_valid dropped
  task automatic issue_one(input logic [IDW-1:0] id, input logic [N-1:0] dd, input logic [M-1:0] dv,
                           input logic [N-1:0] q, input logic [M-1:0] r, input logic dz);
    logic ok;
    set_op(id, dd, dv, q, r, dz);
    req_valid = NREQ'(1) << id;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    chk("handshake_timeout", 64'(ok), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int lat;
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    inj       = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(IDW'(i), '0, 32'd1, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_data_rdy", 64'(div_data_rdy), 64'(0));
    chk("rst_dividend", 64'(div_dividend), 64'(0));
    chk("rst_divisor", 64'(div_divisor), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_fields", 64'({res_id, res_quot, res_rem} != '0), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_orphan", 64'(err_orphan), 64'(0));
`ifdef DIV_ZERO_CHK_EN
    chk("rst_res_dz", 64'(res_dz), 64'(0));
`endif
    rst = 1'b0;

    // Single op: issue strobe one cycle later, result N+1 edges after handshake
    @(posedge clk); #1;
    issue_one(2'd0, 32'd29, 32'd5, 32'd5, 32'd4, 1'b0);
    chk("issue_data_rdy", 64'(div_data_rdy), 64'(1));
    chk("issue_dividend", 64'(div_dividend), 64'(29));
    chk("issue_divisor", 64'(div_divisor), 64'(5));
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("data_rdy_drop", 64'(div_data_rdy), 64'(0));
    end
    chk("latency", 64'(lat), 64'(N + 1));
    wait_idle();

    // All four continuously valid: round-robin grants, results in grant order
    set_op(2'd0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    set_op(2'd1, -32'd100, 32'd7, -32'd14, -32'd2, 1'b0);
    set_op(2'd2, 32'd1000, -32'd3, -32'd333, 32'd1, 1'b0);
    set_op(2'd3, -32'd7, -32'd2, 32'd3, -32'd1, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    // Credit exhaustion with the consumer stalled, then one pop frees one slot
    set_op(2'd0, 32'd12345, 32'd10, 32'd1234, 32'd5, 1'b0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 4'b0001;
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
    end
    chk("credit_accepts", 64'(acc), 64'(CRED));
    chk("credit_block", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
    end
    chk("credit_one_more", 64'(acc), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle();

    // Signed operands
    issue_one(2'd2, -32'd29, 32'd5, -32'd5, -32'd4, 1'b0);
    issue_one(2'd2, 32'd29, -32'd5, -32'd5, 32'd4, 1'b0);
    wait_idle();

`ifdef DIV_ZERO_CHK_EN
    // Zero divisor saturates; the following op is unaffected
    issue_one(2'd0, 32'd100, 32'd0, 32'h7FFF_FFFF, 32'd100, 1'b1);
    issue_one(2'd0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    wait_idle();
`endif

    // Reset with ten ops in flight, then an orphan divider pulse
    set_op(2'd1, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 4'b0010;
    acc = 0;
    for (int c = 0; c < 50 && acc < 10; c++) begin
      @(negedge clk);
      if (req_ready[1]) acc++;
    end
    chk("inflight_accepts", 64'(acc), 64'(10));
    @(posedge clk); #1;
    req_valid = 4'hF;
    rst       = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    chk("rst_mid_data_rdy", 64'(div_data_rdy), 64'(0));
    chk("rst_mid_res_valid", 64'(res_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_dividend", 64'(div_dividend), 64'(0));
    req_valid = '0;
    rst       = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("orphan_clear", 64'(err_orphan), 64'(0));
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    chk("orphan_set", 64'(err_orphan), 64'(1));
    chk("orphan_no_result", 64'(res_valid), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("orphan_sticky", 64'(err_orphan), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("orphan_rst", 64'(err_orphan), 64'(0));
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
